// File: rtl/mux_n_to_1_pipe_if.sv
// Handshake bundle for mux_n_to_1_pipe: upstream offer (inputs, select,
// valid, flush), downstream acceptance and the registered head entry.
interface mux_n_to_1_pipe_if #(
   parameter int WIDTH    = 32,
   parameter int N_INPUTS = 4,
   parameter int SEL_W    = 2
);
   logic [N_INPUTS*WIDTH-1:0] i_inputs;
   logic [SEL_W-1:0]          i_sel;
   logic                      i_valid;
   logic                      o_ready;
   logic                      i_flush;
   logic [WIDTH-1:0]          o_data;
   logic                      o_sel_err;
   logic                      o_valid;
   logic                      i_ready;
   logic [1:0]                o_count;

   // Block side
   modport slave (
      input  i_inputs, i_sel, i_valid, i_flush, i_ready,
      output o_ready, o_data, o_sel_err, o_valid, o_count
   );

   // Environment side
   modport master (
      output i_inputs, i_sel, i_valid, i_flush, i_ready,
      input  o_ready, o_data, o_sel_err, o_valid, o_count
   );
endinterface

// File: rtl/mux_n_to_1_pipe.sv
// Registered N:1 selector behind a valid/ready handshake. A head register
// plus one skid register give full throughput under back-pressure while
// o_ready stays a pure register output. Out-of-range selects push zero data
// tagged with an error flag that travels with the entry.
module mux_n_to_1_pipe #(
   parameter int WIDTH    = 32,
   parameter int N_INPUTS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   mux_n_to_1_pipe_if.slave      bus
);

   logic [WIDTH-1:0] w_in [N_INPUTS];
   logic [WIDTH-1:0] w_push_data;
   logic             w_push_err;
   logic             w_accept;
   logic             w_pop;

   logic [WIDTH-1:0] r_main_data, w_main_data_next;
   logic             r_main_err,  w_main_err_next;
   logic [WIDTH-1:0] r_skid_data, w_skid_data_next;
   logic             r_skid_err,  w_skid_err_next;
   logic [1:0]       r_count,     w_count_next;
   logic             r_ready,     w_ready_next;

   // Split the flattened input bus into one word per selectable input
   genvar gi;
   generate
      for (gi = 0; gi < N_INPUTS; gi++) begin : g_unpack
         assign w_in[gi] = bus.i_inputs[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Select the pushed word; unmatched (unused) select codes give zero + error
   always_comb begin
      w_push_data = '0;
      w_push_err  = 1'b1;
      for (int k = 0; k < N_INPUTS; k++) begin
         if (bus.i_sel == SEL_W'(k)) begin
            w_push_data = w_in[k];
            w_push_err  = 1'b0;
         end
      end
   end

   assign w_accept = bus.i_valid & r_ready;
   assign w_pop    = (r_count != 2'd0) & bus.i_ready;

   // Occupancy transitions; flush overrides accept and pop
   always_comb begin
      w_main_data_next = r_main_data;
      w_main_err_next  = r_main_err;
      w_skid_data_next = r_skid_data;
      w_skid_err_next  = r_skid_err;
      w_count_next     = r_count;
      if (bus.i_flush) begin
         w_main_data_next = '0;
         w_main_err_next  = 1'b0;
         w_skid_data_next = '0;
         w_skid_err_next  = 1'b0;
         w_count_next     = 2'd0;
      end else begin
         case (r_count)
            2'd0: begin
               if (w_accept) begin
                  w_main_data_next = w_push_data;
                  w_main_err_next  = w_push_err;
                  w_count_next     = 2'd1;
               end
            end
            2'd1: begin
               if (w_accept && w_pop) begin
                  w_main_data_next = w_push_data;
                  w_main_err_next  = w_push_err;
               end else if (w_accept) begin
                  w_skid_data_next = w_push_data;
                  w_skid_err_next  = w_push_err;
                  w_count_next     = 2'd2;
               end else if (w_pop) begin
                  // Emptied head is zeroed so stale data never lingers
                  w_main_data_next = '0;
                  w_main_err_next  = 1'b0;
                  w_count_next     = 2'd0;
               end
            end
            2'd2: begin
               if (w_pop) begin
                  w_main_data_next = r_skid_data;
                  w_main_err_next  = r_skid_err;
                  w_skid_data_next = '0;
                  w_skid_err_next  = 1'b0;
                  w_count_next     = 2'd1;
               end
            end
            default: begin
               w_count_next = 2'd0;
            end
         endcase
      end
      w_ready_next = (w_count_next < 2'd2);
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_main_data <= '0;
         r_main_err  <= 1'b0;
         r_skid_data <= '0;
         r_skid_err  <= 1'b0;
         r_count     <= 2'd0;
         r_ready     <= 1'b1;
      end else begin
         r_main_data <= w_main_data_next;
         r_main_err  <= w_main_err_next;
         r_skid_data <= w_skid_data_next;
         r_skid_err  <= w_skid_err_next;
         r_count     <= w_count_next;
         r_ready     <= w_ready_next;
      end
   end

   assign bus.o_data    = r_main_data;
   assign bus.o_sel_err = r_main_err;
   assign bus.o_valid   = (r_count != 2'd0);
   assign bus.o_ready   = r_ready;
   assign bus.o_count   = r_count;

endmodule

// File: doc/mux_n_to_1_pipe.md
Name: mux_n_to_1_pipe

Overview:
- Parametrised, registered N-input selector that replaces the combinational 2:1 mux wherever a selected operand must cross a pipeline boundary, e.g. the EX-stage operand and forwarding selects.
- Performs the select, then registers the result behind a valid/ready handshake.
- A 2-entry skid buffer sustains full throughput while allowing back-pressure from the downstream stage.
- Supports stage flush and flags out-of-range selects.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_INPUTS, 4, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_INPUTS.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_inputs  input  N_INPUTS*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- i_sel  input  SEL_W  selects input i_sel.
- i_valid  input  1  upstream offers {i_inputs, i_sel}.
- o_ready  output  1  block can accept; registered.
- i_flush  input  1  synchronous clear of all buffered entries.
- o_data  output  WIDTH  selected data of the head entry.
- o_sel_err  output  1  head entry was captured with i_sel >= N_INPUTS.
- o_valid  output  1  head entry valid.
- i_ready  input  1  downstream accepts the head entry.
- o_count  output  2  occupancy, 0..2.

Behaviour:
- Reset (i_reset low, asynchronous): o_valid=0, o_ready=1, o_data=0, o_sel_err=0, o_count=0, skid entry cleared. Reset held mid-transfer discards all entries. Release takes effect at the next edge.
- Accept: accept = i_valid & o_ready. Push data = i_inputs[i_sel*WIDTH +: WIDTH] when i_sel < N_INPUTS. Otherwise push data = 0 with err=1.
- Pop: pop = o_valid & i_ready.
- Storage: main (head) register drives o_data and o_sel_err. The skid register holds a second entry.
- Latency: an entry accepted at edge t appears on o_valid/o_data after edge t when main is empty or popping at t. No combinational path from any input to any output.
- Transitions by occupancy:
  - count 0, accept: main <= push; count -> 1.
  - count 1:
    - accept & pop: main <= push; count stays 1.
    - accept & !pop: skid <= push; count -> 2.
    - pop & !accept: count -> 0.
  - count 2 (o_ready=0, so no accept): pop moves main <= skid; count -> 1.
- o_ready = (count_next < 2), registered. It deasserts the cycle after the skid fills and reasserts the cycle after a pop from count 2.
- Ordering: strictly FIFO; entries never reorder or duplicate.
- Flush:
  - i_flush=1 has priority over accept and pop in the same cycle.
  - Next state: count=0, o_valid=0, o_ready=1, o_data=0, o_sel_err=0.
  - An input offered in the flush cycle is dropped.
  - A pop coincident with flush is treated as taken by downstream.
- i_valid low: i_sel and i_inputs are don't-care; no state change except pop.
- Sizing: N_INPUTS non power of two leaves unused select codes; these are the out-of-range case. o_sel_err has no sticky behaviour and travels with its entry.
- X-safety: no X may propagate to o_data when i_valid=0.

Test Plan:
- Reset: drive i_reset low mid-stream with count=2 -> all outputs take reset values immediately; after release and one edge, o_ready=1.
- Select sweep: WIDTH=32, N_INPUTS=4, inputs {10,20,30,40}, i_ready=1, i_sel=0..3 on consecutive cycles -> o_data=10,20,30,40 one cycle later each, o_valid continuous, o_count=1.
- Back-pressure: push 0xA then 0xB with i_ready=0 -> o_count=2, o_ready=0, o_data=0xA. Raise i_ready -> 0xA popped, o_data=0xB next, o_ready=1 one cycle later, no loss.
- Out-of-range select: N_INPUTS=3, i_sel=3 -> o_data=0, o_sel_err=1 for that entry only; next entry with i_sel=1 gives o_sel_err=0.
- Flush collision: count=2, i_flush=1 with i_valid=1 and i_sel=2 -> next cycle o_valid=0, o_count=0, o_ready=1; the offered entry never appears.
- Randomised throughput: random i_valid and i_ready for 1000 cycles -> output sequence equals the scoreboard FIFO of accepted selections; no accept while o_ready=0.
